// File: rtl/oam_pkg.sv
// Shared types and helpers for the OAM memory and its DMA engine.
// Byte offsets are striped across RD_BYTES banks so a PPU word is one row of every bank.
package oam_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DELAY = 3'd1,
    REQ   = 3'd2,
    WAIT  = 3'd3,
    PACE  = 3'd4
  } dma_state_t;

  localparam logic [15:0] OAM_BASE = 16'hFE00;
  localparam logic [15:0] DMA_REG  = 16'hFF46;

  function automatic logic [7:0] oam_bank(input logic [7:0] addr, input int unsigned rd_bytes);
    return 8'(32'(addr) % rd_bytes);
  endfunction

  function automatic logic [7:0] oam_row(input logic [7:0] addr, input int unsigned rd_bytes);
    return 8'(32'(addr) / rd_bytes);
  endfunction

endpackage

// File: rtl/oam_dma_ctrl.sv
// OAM DMA sequencer: start delay, paced one-byte source requests, single byte write port into OAM.
// Handshake: dma_req_o is a one-cycle pulse; the source answers later with one dma_rvalid_i cycle.
module oam_dma_ctrl
  import oam_pkg::*;
#(
  parameter int DMA_LEN     = 160,
  parameter int DMA_STEP    = 4,
  parameter int START_DELAY = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        dma_start_i,
  input  logic [7:0]  dma_page_i,
  input  logic        dma_rvalid_i,
  input  logic [7:0]  dma_rdata_i,
  output logic        dma_req_o,
  output logic [15:0] dma_src_addr_o,
  output logic        wr_en_o,
  output logic [7:0]  wr_addr_o,
  output logic [7:0]  wr_data_o,
  output dma_state_t  state_o
);

  localparam int IDX_W  = (DMA_LEN > 1) ? $clog2(DMA_LEN) : 1;
  localparam int STEP_W = $clog2(DMA_STEP + 1);
  localparam int DLY_W  = (START_DELAY > 1) ? $clog2(START_DELAY + 1) : 1;

  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DMA_LEN - 1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(DMA_STEP - 1);
  localparam logic [STEP_W-1:0] STEP_MAX  = STEP_W'(DMA_STEP);
  localparam logic [DLY_W-1:0]  DLY_LAST  = DLY_W'((START_DELAY > 1) ? START_DELAY - 1 : 0);

  dma_state_t        state_q;
  logic [7:0]        page_q;
  logic [IDX_W-1:0]  idx_q;
  logic [IDX_W-1:0]  idx_inc;
  logic [DLY_W-1:0]  dly_q;
  logic [STEP_W-1:0] step_q;
  logic              dma_req_q;
  logic [15:0]       src_q;

  assign idx_inc = idx_q + 1'b1;

  // step_q counts cycles since the last request edge; a late source leaves it saturated,
  // so the next request follows rvalid by exactly one cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      page_q    <= 8'h00;
      idx_q     <= '0;
      dly_q     <= '0;
      step_q    <= '0;
      dma_req_q <= 1'b0;
      src_q     <= 16'h0000;
    end else begin
      dma_req_q <= 1'b0;
      if (step_q != STEP_MAX) step_q <= step_q + 1'b1;
      if (dma_start_i) begin
        state_q <= DELAY;
        page_q  <= dma_page_i;
        idx_q   <= '0;
        dly_q   <= DLY_W'(1);
      end else begin
        unique case (state_q)
          IDLE: ;
          DELAY: begin
            if (dly_q >= DLY_LAST) begin
              state_q   <= REQ;
              dma_req_q <= 1'b1;
              src_q     <= {page_q, 8'(idx_q)};
            end else begin
              dly_q <= dly_q + 1'b1;
            end
          end
          REQ: begin
            state_q <= WAIT;
            step_q  <= STEP_W'(1);
          end
          WAIT: begin
            if (dma_rvalid_i) begin
              if (idx_q == IDX_LAST) begin
                state_q <= IDLE;
              end else begin
                idx_q <= idx_inc;
                if (step_q >= STEP_LAST) begin
                  state_q   <= REQ;
                  dma_req_q <= 1'b1;
                  src_q     <= {page_q, 8'(idx_inc)};
                end else begin
                  state_q <= PACE;
                end
              end
            end
          end
          PACE: begin
            if (step_q >= STEP_LAST) begin
              state_q   <= REQ;
              dma_req_q <= 1'b1;
              src_q     <= {page_q, 8'(idx_q)};
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign wr_en_o        = (state_q == WAIT) && dma_rvalid_i && !dma_start_i;
  assign wr_addr_o      = 8'(idx_q);
  assign wr_data_o      = dma_rdata_i;
  assign dma_req_o      = dma_req_q;
  assign dma_src_addr_o = src_q;
  assign state_o        = state_q;

endmodule

// File: rtl/oam_dma_ram.sv
// Sprite attribute memory: byte CPU port, RD_BYTES-wide PPU port, integrated OAM DMA.
// CPU access is blocked while DMA runs; PPU reads never are.
module oam_dma_ram
  import oam_pkg::*;
#(
  parameter int OAM_BYTES   = 160,
  parameter int RD_BYTES    = 2,
  parameter int DMA_LEN     = 160,
  parameter int DMA_STEP    = 4,
  parameter int START_DELAY = 4
) (
  input  logic                                   clk,
  input  logic                                   reset_n,
  input  logic                                   cpu_we,
  input  logic                                   cpu_re,
  input  logic [7:0]                             cpu_addr,
  input  logic [7:0]                             cpu_wdata,
  output logic [7:0]                             cpu_rdata,
  input  logic                                   ppu_re,
  input  logic [$clog2(OAM_BYTES/RD_BYTES)-1:0]  ppu_addr,
  output logic [8*RD_BYTES-1:0]                  ppu_rdata,
  input  logic                                   dma_start,
  input  logic [7:0]                             dma_page,
  output logic                                   dma_req,
  output logic [15:0]                            dma_src_addr,
  input  logic                                   dma_rvalid,
  input  logic [7:0]                             dma_rdata,
  output logic                                   dma_active
);

  localparam int ROWS   = OAM_BYTES / RD_BYTES;
  localparam int ROW_W  = $clog2(ROWS);
  localparam int BANK_W = (RD_BYTES > 1) ? $clog2(RD_BYTES) : 1;

  logic [7:0] mem [RD_BYTES][ROWS];

  dma_state_t          dma_state;
  logic                dma_wr_en;
  logic [7:0]          dma_wr_addr;
  logic [7:0]          dma_wr_data;
  logic                cpu_in_range;
  logic                ppu_in_range;
  logic                cpu_wr_ok;
  logic                wr_en;
  logic [7:0]          wr_addr;
  logic [7:0]          wr_data;
  logic [8*RD_BYTES-1:0] ppu_word;
  logic [7:0]          cpu_rdata_q;
  logic [8*RD_BYTES-1:0] ppu_rdata_q;

  oam_dma_ctrl #(
    .DMA_LEN     (DMA_LEN),
    .DMA_STEP    (DMA_STEP),
    .START_DELAY (START_DELAY)
  ) u_ctrl (
    .clk_i          (clk),
    .rst_ni         (reset_n),
    .dma_start_i    (dma_start),
    .dma_page_i     (dma_page),
    .dma_rvalid_i   (dma_rvalid),
    .dma_rdata_i    (dma_rdata),
    .dma_req_o      (dma_req),
    .dma_src_addr_o (dma_src_addr),
    .wr_en_o        (dma_wr_en),
    .wr_addr_o      (dma_wr_addr),
    .wr_data_o      (dma_wr_data),
    .state_o        (dma_state)
  );

  // Active exactly while the sequencer is out of IDLE, so it drops the cycle after the last byte.
  assign dma_active   = (dma_state != IDLE);
  assign cpu_in_range = 32'(cpu_addr) < OAM_BYTES;
  assign ppu_in_range = 32'(ppu_addr) < ROWS;
  assign cpu_wr_ok    = cpu_we && cpu_in_range && !dma_active;

  // DMA only writes while active, which already locks the CPU out: the two never collide.
  assign wr_en   = dma_wr_en || cpu_wr_ok;
  assign wr_addr = dma_wr_en ? dma_wr_addr : cpu_addr;
  assign wr_data = dma_wr_en ? dma_wr_data : cpu_wdata;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[BANK_W'(oam_bank(wr_addr, RD_BYTES))][ROW_W'(oam_row(wr_addr, RD_BYTES))] <= wr_data;
    end
  end

  for (genvar b = 0; b < RD_BYTES; b++) begin : g_lane
    assign ppu_word[8*b +: 8] = mem[b][ppu_addr];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cpu_rdata_q <= 8'hFF;
      ppu_rdata_q <= '1;
    end else begin
      if (cpu_re) begin
        cpu_rdata_q <= (cpu_in_range && !dma_active)
                       ? mem[BANK_W'(oam_bank(cpu_addr, RD_BYTES))][ROW_W'(oam_row(cpu_addr, RD_BYTES))]
                       : 8'hFF;
      end
      if (ppu_re) begin
        ppu_rdata_q <= ppu_in_range ? ppu_word : '1;
      end
    end
  end

  assign cpu_rdata = cpu_rdata_q;
  assign ppu_rdata = ppu_rdata_q;

endmodule

// File: tb/tb_oam_dma_ram.sv
// Directed bench for oam_dma_ram: CPU/PPU ports, paced DMA, restart and reset abort.
// A negedge source model answers requests and checks their addresses and spacing.
module tb_oam_dma_ram;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cpu_we = 1'b0;
  logic        cpu_re = 1'b0;
  logic [7:0]  cpu_addr = 8'h00;
  logic [7:0]  cpu_wdata = 8'h00;
  logic [7:0]  cpu_rdata;
  logic        ppu_re = 1'b0;
  logic [6:0]  ppu_addr = 7'h00;
  logic [15:0] ppu_rdata;
  logic        dma_start = 1'b0;
  logic [7:0]  dma_page = 8'h00;
  logic        dma_req;
  logic [15:0] dma_src_addr;
  logic        dma_rvalid = 1'b0;
  logic [7:0]  dma_rdata = 8'h00;
  logic        dma_active;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0]  exp_mem [256];
  logic [15:0] exp_q[$];

  int          lat = 1;
  int          exp_gap = 4;
  int          start_cyc = 0;
  int          last_req = 0;
  int          last_rv = 0;
  int          rv_cnt = 0;
  int          req_cnt = 0;
  bit          first_req = 1'b0;
  bit          pend = 1'b0;
  int          pend_cyc = 0;
  logic [15:0] pend_addr = 16'h0000;

  oam_dma_ram dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .cpu_we       (cpu_we),
    .cpu_re       (cpu_re),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_rdata    (cpu_rdata),
    .ppu_re       (ppu_re),
    .ppu_addr     (ppu_addr),
    .ppu_rdata    (ppu_rdata),
    .dma_start    (dma_start),
    .dma_page     (dma_page),
    .dma_req      (dma_req),
    .dma_src_addr (dma_src_addr),
    .dma_rvalid   (dma_rvalid),
    .dma_rdata    (dma_rdata),
    .dma_active   (dma_active)
  );

  // clock / reset / watchdog
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // source page content: page C1 gives addr^5A, page D0 gives addr^4B
  function automatic logic [7:0] src_byte(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h9B;
  endfunction

  // source model
  initial forever begin
    @(negedge clk);
    if (pend && cyc == pend_cyc) begin
      dma_rvalid = 1'b1;
      dma_rdata  = src_byte(pend_addr);
      pend       = 1'b0;
      rv_cnt++;
      last_rv    = cyc;
    end else begin
      dma_rvalid = 1'b0;
    end
    if (dma_req) begin
      check("req_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) check("req_addr", dma_src_addr, exp_q.pop_front());
      if (first_req) check("first_req_delay", cyc - start_cyc, 4);
      else           check("req_gap", cyc - last_req, exp_gap);
      first_req = 1'b0;
      pend      = 1'b1;
      pend_cyc  = cyc + lat;
      pend_addr = dma_src_addr;
      req_cnt++;
      last_req  = cyc;
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(input logic [7:0] a, input logic [7:0] d);
    cpu_we = 1'b1; cpu_addr = a; cpu_wdata = d;
    tick();
    cpu_we = 1'b0;
  endtask

  task automatic cpu_read(input logic [7:0] a, output logic [7:0] d);
    cpu_re = 1'b1; cpu_addr = a;
    tick();
    cpu_re = 1'b0;
    d = cpu_rdata;
  endtask

  task automatic ppu_read(input logic [6:0] a, output logic [15:0] w);
    ppu_re = 1'b1; ppu_addr = a;
    tick();
    ppu_re = 1'b0;
    w = ppu_rdata;
  endtask

  task automatic dma_go(input logic [7:0] page);
    dma_start = 1'b1; dma_page = page;
    start_cyc = cyc;
    exp_q.delete();
    for (int i = 0; i < 160; i++) exp_q.push_back({page, 8'(i)});
    first_req = 1'b1; pend = 1'b0; rv_cnt = 0; req_cnt = 0;
    tick();
    dma_start = 1'b0;
  endtask

  task automatic wait_rv(input int n);
    int b = 0;
    while (rv_cnt < n && b < 2000) begin tick(); b++; end
    check("wait_rv", rv_cnt, n);
  endtask

  task automatic wait_idle(input string tag);
    int b = 0;
    while (dma_active && b < 4000) begin tick(); b++; end
    check({tag, "_idle"}, 32'(dma_active), 32'd0);
    check({tag, "_active_fall"}, cyc - last_rv, 1);
    check({tag, "_rv_cnt"}, rv_cnt, 160);
    check({tag, "_req_cnt"}, req_cnt, 160);
  endtask

  task automatic model_fill(input logic [7:0] page, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) exp_mem[i] = src_byte({page, 8'(i)});
  endtask

  task automatic verify_oam(input string tag);
    logic [7:0]  d;
    logic [15:0] w;
    for (int i = 0; i < 160; i++) begin
      cpu_read(8'(i), d);
      check($sformatf("%s_oam[%0d]", tag, i), d, exp_mem[i]);
    end
    ppu_read(7'd5, w);
    check({tag, "_ppu_w5"}, w, {exp_mem[11], exp_mem[10]});
  endtask

  initial begin
    logic [7:0]  d;
    logic [15:0] w;

    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    tick();
    check("rst_cpu_rdata", cpu_rdata, 8'hFF);
    check("rst_ppu_rdata", ppu_rdata, 16'hFFFF);
    check("rst_active", 32'(dma_active), 32'd0);
    check("rst_req", 32'(dma_req), 32'd0);
    check("rst_src_addr", dma_src_addr, 16'h0000);

    for (int i = 0; i < 160; i++) begin
      cpu_write(8'(i), 8'(i));
      exp_mem[i] = 8'(i);
    end
    cpu_write(8'd200, 8'h55);
    cpu_read(8'd200, d);
    check("cpu_oor_read", d, 8'hFF);
    ppu_read(7'd5, w);
    check("ppu_word5", w, 16'h0B0A);
    ppu_read(7'd80, w);
    check("ppu_oor_read", w, 16'hFFFF);
    cpu_read(8'd7, d);
    check("cpu_read7", d, 8'h07);
    tick();
    check("cpu_rdata_hold", cpu_rdata, 8'h07);

    cpu_we = 1'b1; cpu_re = 1'b1; cpu_addr = 8'd9; cpu_wdata = 8'hEE;
    tick();
    cpu_we = 1'b0; cpu_re = 1'b0;
    check("rdw_old_data", cpu_rdata, 8'h09);
    cpu_read(8'd9, d);
    check("rdw_new_data", d, 8'hEE);
    exp_mem[9] = 8'hEE;

    // page C1, one-cycle source; blocked CPU access while running
    lat = 1; exp_gap = 4;
    dma_go(8'hC1);
    repeat (38) tick();
    cpu_read(8'd3, d);
    check("dma_cpu_read_blocked", d, 8'hFF);
    cpu_write(8'd3, 8'h77);
    ppu_read(7'd1, w);
    check("dma_ppu_word1", w, 16'h5958);
    wait_idle("c1");
    model_fill(8'hC1, 0, 159);
    verify_oam("c1");

    // restart with page D0 once 50 bytes are in
    dma_go(8'hC1);
    wait_rv(50);
    dma_go(8'hD0);
    wait_idle("restart");
    model_fill(8'hD0, 0, 159);
    verify_oam("restart");

    // slow source: six-cycle latency
    lat = 6; exp_gap = 7;
    dma_go(8'hC1);
    wait_idle("slow");
    model_fill(8'hC1, 0, 159);
    verify_oam("slow");

    // reset in the middle of a transfer
    lat = 1; exp_gap = 4;
    dma_go(8'hD0);
    wait_rv(20);
    reset_n = 1'b0;
    #1;
    check("abort_active", 32'(dma_active), 32'd0);
    check("abort_req", 32'(dma_req), 32'd0);
    check("abort_src_addr", dma_src_addr, 16'h0000);
    check("abort_cpu_rdata", cpu_rdata, 8'hFF);
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    check("abort_idle", 32'(dma_active), 32'd0);
    model_fill(8'hD0, 0, 19);
    verify_oam("abort");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/oam_dma_ram.md
Name: oam_dma_ram

Overview:
- Parametrised sprite-attribute memory with an integrated OAM DMA engine.
- Byte-wide CPU read/write port; wide read port for the PPU sprite fetcher (RD_BYTES bytes per access).
- The DMA engine copies DMA_LEN bytes from a 256-byte source page into OAM, one byte per DMA_STEP cycles, while blocking CPU access.
- Sits between the CPU bus decoder (0xFE00-0xFE9F, 0xFF46) and the PPU object fetch stage.

Parameters:
- OAM_BYTES, 160, OAM size in bytes; must be a multiple of RD_BYTES.
- RD_BYTES, 2, bytes returned per PPU read; power of two, 1..4.
- DMA_LEN, 160, bytes copied per DMA; must be <= OAM_BYTES.
- DMA_STEP, 4, clock cycles per transferred byte; must be >= 2.
- START_DELAY, 4, idle cycles between dma_start and the first source request.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- cpu_we  in  1  CPU write strobe, single cycle
- cpu_re  in  1  CPU read strobe, single cycle
- cpu_addr  in  8  OAM byte offset
- cpu_wdata  in  8  CPU write data
- cpu_rdata  out  8  CPU read data
- ppu_re  in  1  PPU read strobe
- ppu_addr  in  clog2(OAM_BYTES/RD_BYTES)  word index
- ppu_rdata  out  8*RD_BYTES  word, little-endian: byte 0 is in [7:0]
- dma_start  in  1  start pulse (write to 0xFF46)
- dma_page  in  8  source high byte
- dma_req  out  1  source read request, one-cycle pulse
- dma_src_addr  out  16  {page, index}
- dma_rvalid  in  1  source data valid
- dma_rdata  in  8  source data
- dma_active  out  1  high while a transfer is in progress

Behaviour:
- Reset (async assert, sync release): state IDLE, dma_active=0, dma_req=0, dma_src_addr=0, cpu_rdata=8'hFF, ppu_rdata=all ones, index=0. RAM contents are not cleared.
- Storage: RD_BYTES byte banks, each OAM_BYTES/RD_BYTES deep. Byte offset a maps to bank a%RD_BYTES, row a/RD_BYTES.
- CPU write: when cpu_we=1, cpu_addr<OAM_BYTES and dma_active=0, the byte is written at the clock edge. Otherwise the write is dropped.
- CPU read: 1-cycle latency. cpu_rdata is registered on cpu_re and holds otherwise. It returns 8'hFF if cpu_addr>=OAM_BYTES or dma_active=1 at the request cycle.
- Read-during-write on the CPU port at the same address returns the old data.
- PPU read: 1-cycle latency, registered on ppu_re, holds otherwise. PPU reads are never blocked by DMA. Same-cycle DMA write to the same row returns old data. ppu_addr beyond range returns all ones.
- DMA FSM:
  - IDLE: on dma_start, latch dma_page, index=0, dma_active=1, go to DELAY.
  - DELAY: count START_DELAY cycles, then go to REQ.
  - REQ: pulse dma_req one cycle with dma_src_addr={page,index}, go to WAIT.
  - WAIT: on dma_rvalid, write dma_rdata at OAM offset index.
    - If index==DMA_LEN-1, go to IDLE and drop dma_active on the next cycle.
    - Else index++ and go to PACE.
  - PACE: hold until DMA_STEP cycles have elapsed since the previous dma_req edge, then go to REQ. If the source responds late, the next request issues 1 cycle after rvalid.
- dma_rvalid outside WAIT is ignored.
- dma_start while active: restarts immediately from DELAY with the new page and index=0. A pending rvalid in that same cycle is discarded.
- cpu_we in the same cycle as dma_start: the write is performed, since dma_active is still 0.
- Counters: index width is clog2(DMA_LEN). The step counter saturates; no wrap is permitted.
- Reset mid-DMA aborts the transfer. Bytes already copied remain in RAM.

Decomposition:
- Shared package oam_pkg:
  - dma_state_t enum {IDLE, DELAY, REQ, WAIT, PACE}
  - OAM_BASE=16'hFE00, DMA_REG=16'hFF46
  - function for byte-to-bank/row mapping
- One natural sub-module: oam_dma_ctrl, containing the FSM, counters and source handshake. It drives a single byte write port into the RAM banks of oam_dma_ram.

Test Plan:
- After reset: cpu_rdata=FF, ppu_rdata=FFFF, dma_active=0. CPU writes 0x00..0x9F to offsets 0..159. PPU read word 5 returns 16'h0B0A one cycle later.
- dma_start with page 0xC1 and a 1-cycle-latency source returning (addr[7:0]^0x5A):
  - First dma_req appears START_DELAY cycles after start, with addresses C100..C19F.
  - Requests are spaced exactly 4 cycles.
  - Afterwards OAM[i]==i^0x5A, and dma_active is low one cycle after the 160th rvalid.
- During DMA: cpu_re at offset 3 returns FF, and cpu_we 0x77 at offset 3 is dropped. PPU read of word 1 returns the current RAM contents.
- Source with 6-cycle latency: the next dma_req comes 1 cycle after each rvalid, and the transfer completes correctly.
- dma_start(0xD0) issued at index 50 of a 0xC1 transfer: index restarts at 0. OAM[0..159] end up with page 0xD0 data.
- reset_n asserted mid-DMA at index 20: dma_active=0 and dma_req=0 immediately. Bytes 0..19 are retained, and bytes 20+ keep their prior values.
